// File: rtl/verinject_schedule_injector.sv
// Schedule-driven fault injector: replays queued (cycle, bit) events onto the
// verinject__injector_state bus, one bit index per matching cycle.
module verinject_schedule_injector #(
  parameter int unsigned TOTAL_BITS = 0,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = 48,
  localparam int unsigned BW        = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arm,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_cycle,
  input  logic [BW-1:0] cfg_bit,
  output logic [CW-1:0] cycle_number,
  output logic [BW-1:0] verinject__injector_state,
  output logic [AW:0]   pending,
  output logic          range_error,
  output logic          late_error,
  output logic [BW-1:0] injected_count
);

  typedef struct packed {
    logic [CW-1:0] cyc;
    logic [BW-1:0] idx;
  } event_t;

  event_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  event_t        head;
  logic          resolve;
  logic          due;
  logic          late;
  logic          pop;
  logic          push;
  logic          in_range;
  logic          accept;
  logic          reject;

  // A zero-sized injectable space rejects every event.
  generate
    if (TOTAL_BITS == 0) begin : g_no_bits
      assign in_range = 1'b0;
    end else begin : g_bits
      assign in_range = cfg_bit < BW'(TOTAL_BITS);
    end
  endgenerate

  assign head      = mem[rd_ptr];
  assign cfg_ready = pending != (AW+1)'(DEPTH);
  assign resolve   = arm && (pending != '0);
  assign due       = resolve && (head.cyc == cycle_number);
  assign late      = resolve && (head.cyc < cycle_number);
  assign pop       = due || late;
  assign push      = cfg_valid && cfg_ready;
  assign accept    = push && in_range;
  assign reject    = push && !in_range;

  // The bus shows the head's bit during the cycle its target cycle is current.
  assign verinject__injector_state = (due && !reset) ? head.idx : '1;

  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr] <= '{cyc: cfg_cycle, idx: cfg_bit};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_number   <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      pending        <= '0;
      range_error    <= 1'b0;
      late_error     <= 1'b0;
      injected_count <= '0;
    end else begin
      if (arm) begin
        cycle_number <= cycle_number + CW'(1);
      end
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      pending <= pending + (AW+1)'(accept) - (AW+1)'(pop);
      if (reject) begin
        range_error <= 1'b1;
      end
      if (late) begin
        late_error <= 1'b1;
      end
      if (due) begin
        injected_count <= injected_count + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_verinject_schedule_injector.sv
// Bench for verinject_schedule_injector: directed scenarios plus random traffic,
// checked against an event-list reference model.
module tb_verinject_schedule_injector;

  localparam int unsigned TB_BITS  = 100;
  localparam int unsigned TB_DEPTH = 8;
  localparam logic [31:0] IDLE     = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [47:0] cfg_cycle = '0;
  logic [31:0] cfg_bit = '0;
  logic [47:0] cycle_number;
  logic [31:0] bus;
  logic [3:0]  pending;
  logic        range_error;
  logic        late_error;
  logic [31:0] injected_count;

  verinject_schedule_injector #(.TOTAL_BITS(TB_BITS), .DEPTH(TB_DEPTH)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .arm                      (arm),
    .cfg_valid                (cfg_valid),
    .cfg_ready                (cfg_ready),
    .cfg_cycle                (cfg_cycle),
    .cfg_bit                  (cfg_bit),
    .cycle_number             (cycle_number),
    .verinject__injector_state(bus),
    .pending                  (pending),
    .range_error              (range_error),
    .late_error               (late_error),
    .injected_count           (injected_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [47:0] cyc;
    logic [31:0] idx;
  } ev_t;

  // Reference model: pending events as an ordered list plus counters.
  ev_t         mq[$];
  logic [47:0] m_cycle;
  logic        m_range;
  logic        m_late;
  logic [31:0] m_count;
  int          checks = 0;
  int          errors = 0;
  logic [47:0] last_cyc;
  int          seen17;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_bus(input logic rst, input logic a);
    if (!rst && a && mq.size() > 0 && mq[0].cyc == m_cycle) return mq[0].idx;
    return IDLE;
  endfunction

  // One clock: drive inputs, check outputs mid-cycle, advance model across the edge.
  task automatic step(input logic rst, input logic a, input logic v,
                      input logic [47:0] c, input logic [31:0] b, input logic chk);
    logic ready_m;
    reset = rst; arm = a; cfg_valid = v; cfg_cycle = c; cfg_bit = b;
    #1;
    ready_m = (mq.size() != TB_DEPTH);
    if (chk) begin
      check("bus", 64'(bus), 64'(exp_bus(rst, a)));
      check("cycle_number", 64'(cycle_number), 64'(m_cycle));
      check("pending", 64'(pending), 64'(mq.size()));
      check("cfg_ready", 64'(cfg_ready), 64'(ready_m));
      check("range_error", 64'(range_error), 64'(m_range));
      check("late_error", 64'(late_error), 64'(m_late));
      check("injected_count", 64'(injected_count), 64'(m_count));
    end
    if (bus == 32'd17) seen17++;
    if (rst) begin
      mq.delete(); m_cycle = '0; m_range = 0; m_late = 0; m_count = '0;
    end else begin
      if (a && mq.size() > 0) begin
        if (mq[0].cyc == m_cycle) begin
          void'(mq.pop_front()); m_count++;
        end else if (mq[0].cyc < m_cycle) begin
          void'(mq.pop_front()); m_late = 1;
        end
      end
      if (v && ready_m) begin
        if (b >= TB_BITS) m_range = 1;
        else mq.push_back('{cyc: c, idx: b});
      end
      if (a) m_cycle = m_cycle + 48'd1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic a, input int n);
    for (int i = 0; i < n; i++) step(0, a, 0, '0, '0, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0, '0, 0);
  endtask

  initial begin
    @(posedge clock);
    #1;

    // Single event fires at its cycle only.
    do_reset();
    seen17 = 0;
    step(0, 1, 1, 48'd5, 32'd17, 1);
    idle(1, 10);
    check("s1_count", 64'(injected_count), 64'd1);
    check("s1_pending", 64'(pending), 64'd0);
    check("s1_seen17", 64'(seen17), 64'd1);

    // Same-cycle pair: second is late and dropped.
    do_reset();
    step(0, 0, 1, 48'd3, 32'd1, 1);
    step(0, 0, 1, 48'd3, 32'd2, 1);
    step(0, 0, 1, 48'd9, 32'd40, 1);
    idle(1, 12);
    check("s2_late", 64'(late_error), 64'd1);
    check("s2_count", 64'(injected_count), 64'd2);

    // Out-of-range bit rejected.
    do_reset();
    step(0, 1, 1, 48'd4, 32'd100, 1);
    idle(1, 6);
    check("s3_range", 64'(range_error), 64'd1);
    check("s3_pending", 64'(pending), 64'd0);
    check("s3_count", 64'(injected_count), 64'd0);

    // Fill the queue, stall a 9th push, then drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 48'(20 + i), 32'(i), 1);
    check("s4_ready_full", 64'(cfg_ready), 64'd0);
    step(0, 0, 1, 48'd40, 32'd9, 1);
    step(0, 0, 1, 48'd40, 32'd9, 1);
    check("s4_pending_full", 64'(pending), 64'd8);
    idle(1, 32);
    check("s4_count", 64'(injected_count), 64'd8);

    // Event already in the past when pushed.
    do_reset();
    idle(1, 10);
    step(0, 1, 1, 48'd2, 32'd5, 1);
    idle(1, 4);
    check("s5_late", 64'(late_error), 64'd1);
    check("s5_count", 64'(injected_count), 64'd0);

    // Mid-run reset discards the queue and clears sticky flags.
    do_reset();
    step(0, 1, 1, 48'd50, 32'd7, 1);
    step(0, 1, 1, 48'd1, 32'd200, 1);
    idle(1, 28);
    step(1, 1, 1, 48'd60, 32'd3, 1);
    check("s6_cycle", 64'(cycle_number), 64'd0);
    check("s6_pending", 64'(pending), 64'd0);
    check("s6_range", 64'(range_error), 64'd0);
    idle(1, 60);
    check("s6_count", 64'(injected_count), 64'd0);

    // Random traffic against the model.
    do_reset();
    last_cyc = '0;
    for (int i = 0; i < 600; i++) begin
      logic r, a, v;
      logic [47:0] c;
      logic [31:0] b;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 2) == 0);
      c = ((last_cyc > m_cycle) ? last_cyc : m_cycle) + 48'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) c = last_cyc;
      b = 32'($urandom_range(0, 110));
      if (v && !r && mq.size() != TB_DEPTH) last_cyc = c;
      step(r, a, v, c, b, 1);
      if (r) last_cyc = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/verinject_schedule_injector.md
Name: verinject_schedule_injector

Overview:
- Drives the verinject__injector_state bus consumed by the simulation monitor and by instrumented design modules.
- Holds a small in-order queue of (cycle, bit) injection events loaded by the testbench.
- Compares a free-running cycle counter against the queue head and presents each event's bit index on the bus for exactly one cycle.
- When no event is due, the bus idles at all-ones, meaning "no injection".

Parameters:
- TOTAL_BITS, 0: number of injectable state bits. A bit index is legal only when it is below TOTAL_BITS. With 0, every event is rejected.
- DEPTH, 8: number of queue entries. Must be a power of two, at least 2.

Ports:
- clock  input  1  design clock.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  when 1, the cycle counter advances and due events fire; when 0, both are frozen.
- cfg_valid  input  1  event push request.
- cfg_ready  output  1  queue can accept an event.
- cfg_cycle  input  48  target cycle_number of the event.
- cfg_bit  input  32  bit index to inject.
- cycle_number  output  48  injector's cycle counter.
- verinject__injector_state  output  32  injected bit index, or 32'hFFFFFFFF when idle.
- pending  output  $clog2(DEPTH)+1  number of queued events.
- range_error  output  1  sticky: an event was rejected at push.
- late_error  output  1  sticky: an event was dropped because its cycle had already passed.
- injected_count  output  32  number of events actually fired.

Behaviour:
- Reset (synchronous, active-high) sets:
  - cycle_number = 0, verinject__injector_state = 32'hFFFFFFFF
  - queue empty, pending = 0, cfg_ready = 1
  - range_error = 0, late_error = 0, injected_count = 0
- Reset asserted mid-run discards all queued events. Reset has priority over push and fire in the same cycle.
- cycle_number increments by 1 on each clock edge while arm = 1 and reset = 0. It wraps from 2^48-1 to 0; there is no wrap handling beyond that.
- Push handshake:
  - A push occurs on an edge where cfg_valid = 1 and cfg_ready = 1.
  - cfg_ready = (pending != DEPTH). It is combinational from registered state only.
  - A pushed event with cfg_bit >= TOTAL_BITS is not stored; range_error is set instead. The handshake still completes.
- Queue order: FIFO, in push order. The testbench is responsible for pushing nondecreasing cfg_cycle values. No sorting is done.
- Fire rule, evaluated every cycle with arm = 1 and queue non-empty, against head H:
  - H.cycle == cycle_number: verinject__injector_state equals H.bit during this cycle, i.e. the cycle in which cycle_number reads H.cycle. On the closing edge, H is popped and injected_count increments.
  - H.cycle < cycle_number: H is popped without firing, late_error is set, and the bus stays 32'hFFFFFFFF. At most one entry is resolved per cycle.
  - H.cycle > cycle_number: no action.
- Two events with the same cycle: the first fires; the second becomes late on the next cycle and is dropped.
- With arm = 0: the bus is 32'hFFFFFFFF, there are no pops, and the counter holds.
- Bus output is all-ones in every cycle without a firing.
- Simultaneous push and pop in one cycle:
  - Both take effect and pending is unchanged.
  - A push into a full queue in the same cycle as a pop is not accepted, because cfg_ready was 0.
- A pushed event becomes eligible to fire no earlier than the cycle after its push.
- Arithmetic: cycle comparisons are unsigned 48-bit. injected_count wraps at 2^32.

Test Plan:
- Reset, TOTAL_BITS=100, arm=1, push (5,17) -> bus = 17 only while cycle_number=5; 32'hFFFFFFFF elsewhere; injected_count=1; pending returns to 0.
- Push (3,1), (3,2), (9,40) before arm, then arm -> fire 1 at cycle 3; (3,2) dropped at cycle 4 with late_error=1; fire 40 at cycle 9; injected_count=2.
- Push (4,100) with TOTAL_BITS=100 -> handshake completes, pending stays 0, range_error=1, no firing.
- Push 8 events (cycles 20..27, bits 0..7) with arm=0 -> cfg_ready=0 at pending=8, a 9th push is stalled; arm at cycle 0 -> bits 0..7 appear on cycles 20..27.
- Arm at cycle 10, push (2,5) -> dropped next cycle, late_error=1, bus never shows 5.
- Queue (50,7), run to cycle 30, pulse reset -> cycle_number=0, pending=0, no firing at cycle 50, sticky errors cleared.
